// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, ExcCodes
// and the SYSCALL/ERET encodings also used by the control unit.
package cp0_pkg;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;

   localparam int ST_IE    = 0;
   localparam int ST_SE    = 1;
   localparam int ST_EXL   = 2;
   localparam int ST_IM_LO = 8;
   localparam int CA_IP_LO = 8;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] FN_SYSCALL = 6'h0c;
   localparam logic [31:0] ERET_INSTR = 32'h4200_0018;

   typedef enum logic {
      S_RUN = 1'b0,
      S_EXC = 1'b1
   } cp0_state_e;

   function automatic logic is_syscall(input logic [31:0] instr);
      return (instr[31:26] == OP_SPECIAL) &&
             (instr[5:0] == FN_SYSCALL);
   endfunction

   function automatic logic is_eret(input logic [31:0] instr);
      return instr == ERET_INSTR;
   endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Two-flop synchronizer for the six asynchronous interrupt lines.
module cp0_int_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] async_in,
   output logic [5:0] sync_out
);

   logic [5:0] meta;

   // Plain two-stage shift; sync_out feeds Cause.IP[7:2].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta     <= '0;
         sync_out <= '0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt responder: Status, Cause, EPC and redirect.
// Optional Count/Compare timer enabled by CP0_COUNT_COMPARE_EN.
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  hw_int,
   input  logic        pause,
   input  logic        cu_intr,
   input  logic [31:0] id_instr,
   input  logic [31:0] id_pc,
   input  logic        wb_cp0_wen,
   input  logic [4:0]  wb_cp0_addr,
   input  logic [31:0] wb_cp0_wdata,
   input  logic [4:0]  rd_cp0_addr,
   output logic [31:0] rd_cp0_data,
   output logic [31:0] status_out,
   output logic        intr,
   output logic        exc_redirect,
   output logic [31:0] exc_target
);

   logic [5:0]  hw_sync;
   cp0_state_e  state;
   cp0_state_e  state_nx;
   logic        ie;
   logic        se;
   logic        exl;
   logic [7:0]  im;
   logic [1:0]  ip_sw;
   logic [7:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;
   logic [31:0] cause;
   logic        timer_ip;
   logic        syscall_ev;
   logic        eret_ev;
   logic        intr_ev;
   logic        entry;
   logic        wr_status;
   logic        wr_cause;
   logic        wr_epc;

   cp0_int_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (hw_int),
      .sync_out (hw_sync)
   );

   assign wr_status = wb_cp0_wen && (wb_cp0_addr == REG_STATUS);
   assign wr_cause  = wb_cp0_wen && (wb_cp0_addr == REG_CAUSE);
   assign wr_epc    = wb_cp0_wen && (wb_cp0_addr == REG_EPC);

   assign syscall_ev = ~pause & se & is_syscall(id_instr);
   assign eret_ev    = ~pause & is_eret(id_instr);
   assign intr_ev    = ~pause & cu_intr & ~syscall_ev & ~eret_ev;
   assign entry      = syscall_ev | intr_ev;

`ifdef CP0_COUNT_COMPARE_EN
   logic [31:0] count;
   logic [31:0] compare;
   logic        timer_pend;
   logic        wr_count;
   logic        wr_compare;

   assign wr_count   = wb_cp0_wen && (wb_cp0_addr == REG_COUNT);
   assign wr_compare = wb_cp0_wen && (wb_cp0_addr == REG_COMPARE);

   // Free-running counter; Compare write acknowledges the timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         compare    <= 32'hFFFF_FFFF;
         timer_pend <= 1'b0;
      end else begin
         count <= wr_count ? wb_cp0_wdata : count + 32'd1;
         if (wr_compare)
            compare <= wb_cp0_wdata;
         if (wr_compare)
            timer_pend <= 1'b0;
         else if (count == compare)
            timer_pend <= 1'b1;
      end
   end

   assign timer_ip = timer_pend;
`else
   assign timer_ip = 1'b0;
`endif

   assign exl   = (state == S_EXC);
   assign ip    = {hw_sync[5] | timer_ip, hw_sync[4:0], ip_sw};
   assign cause = {16'b0, ip, 1'b0, exc_code, 2'b00};

   assign status_out = {16'b0, im, 5'b0, exl, se, ie};
   assign intr       = |(ip & im) & ~exl;

   assign exc_redirect = entry | eret_ev;
   assign exc_target   = eret_ev ? epc : EXC_VECTOR;

   // EXL lives in the state register; events override an MTC0 write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_RUN;
      else     state <= state_nx;
   end

   // Next EXL level.
   always_comb begin
      state_nx = state;
      if (entry)
         state_nx = S_EXC;
      else if (eret_ev)
         state_nx = S_RUN;
      else if (wr_status)
         state_nx = wb_cp0_wdata[ST_EXL] ? S_EXC : S_RUN;
   end

   // Status IE/SE/IM: MTC0 first, event touches only IE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ie <= 1'b0;
         se <= 1'b0;
         im <= '0;
      end else begin
         if (wr_status) begin
            ie <= wb_cp0_wdata[ST_IE];
            se <= wb_cp0_wdata[ST_SE];
            im <= wb_cp0_wdata[ST_IM_LO +: 8];
         end
         if (entry)
            ie <= 1'b0;
         else if (eret_ev)
            ie <= 1'b1;
      end
   end

   // Cause software IP bits and ExcCode on entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ip_sw    <= '0;
         exc_code <= EXC_INT;
      end else begin
         if (wr_cause)
            ip_sw <= wb_cp0_wdata[CA_IP_LO +: 2];
         if (entry)
            exc_code <= syscall_ev ? EXC_SYS : EXC_INT;
      end
   end

   // EPC: interrupt re-executes ID, SYSCALL returns past it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         epc <= '0;
      else if (entry)
         epc <= syscall_ev ? id_pc + 32'd4 : id_pc;
      else if (wr_epc)
         epc <= wb_cp0_wdata;
   end

   // MFC0 read mux, no write bypass.
   always_comb begin
      rd_cp0_data = '0;
      case (rd_cp0_addr)
         REG_STATUS:  rd_cp0_data = status_out;
         REG_CAUSE:   rd_cp0_data = cause;
         REG_EPC:     rd_cp0_data = epc;
`ifdef CP0_COUNT_COMPARE_EN
         REG_COUNT:   rd_cp0_data = count;
         REG_COMPARE: rd_cp0_data = compare;
`endif
         default:     rd_cp0_data = '0;
      endcase
   end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception and interrupt responder for the SimMIPS core. It holds Status, Cause, EPC (and optionally Count/Compare) and synchronizes the external interrupt lines. It presents `intr` and `status_out` to the pipeline control unit, and accepts the unit's granted interrupt (`cu_intr`) together with SYSCALL/ERET decoded in ID. It saves the return PC, updates the registers, and drives the PC redirect to the handler or back to EPC.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h0000_0180: handler entry address for interrupts and SYSCALL.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `hw_int`  in  6: external interrupt lines, asynchronous, level-sensitive.
- `pause`  in  1: external pipeline pause; while high, no exception entry or ERET is taken.
- `cu_intr`  in  1: interrupt granted by the control unit this cycle.
- `id_instr`  in  32: instruction in ID, used to decode SYSCALL and ERET.
- `id_pc`  in  32: PC of the instruction in ID.
- `wb_cp0_wen`  in  1: MTC0 write enable, from the WB stage.
- `wb_cp0_addr`  in  5: MTC0 destination register number.
- `wb_cp0_wdata`  in  32: MTC0 write data.
- `rd_cp0_addr`  in  5: MFC0 source register number.
- `rd_cp0_data`  out  32: MFC0 read data, combinational.
- `status_out`  out  32: Status register.
- `intr`  out  1: pending, unmasked interrupt exists.
- `exc_redirect`  out  1: PC redirect strobe.
- `exc_target`  out  32: redirect address.

## Operation
- Status (reg 12) fields:
  - bit0 IE: interrupt enable.
  - bit1 SE: SYSCALL enable.
  - bit2 EXL: exception level.
  - bits15:8 IM: interrupt mask.
  - All other bits read 0.
- Cause (reg 13) fields:
  - bits15:8 IP: IP[7:2] come from the synchronized `hw_int` (read-only). IP[1:0] are software bits written by MTC0.
  - bits6:2 ExcCode: 0 = interrupt, 8 = SYSCALL.
- EPC (reg 14) is fully writable. Unimplemented register numbers read 0 and ignore writes.
- `intr` = |(IP & IM) & ~EXL.
- Event decode:
  - syscall_ev = ~pause & SE & SPECIAL/SYSCALL.
  - eret_ev = ~pause & COP0/ERET.
  - intr_ev = ~pause & cu_intr & ~syscall_ev & ~eret_ev.
- Two-state machine:
  - RUN (EXL=0) → EXC on syscall_ev or intr_ev.
  - EXC → RUN on eret_ev.
  - ERET in RUN still redirects to EPC; EXL stays 0.
  - syscall_ev in EXC is taken: it overwrites EPC and stays in EXC.
- On entry:
  - EPC ← `id_pc` for an interrupt, because the ID instruction is flushed and re-executed.
  - EPC ← `id_pc`+4 for SYSCALL (32-bit wrap).
  - ExcCode is set accordingly; EXL ← 1; IE ← 0.
- On ERET: EXL ← 0, IE ← 1.
- `exc_redirect` = syscall_ev | intr_ev | eret_ev. `exc_target` = EPC on ERET, else `EXC_VECTOR`.
- Same-cycle event and MTC0:
  - The event's updates win for the Status/Cause/EPC fields it touches.
  - MTC0 bits in fields the event does not touch are still applied.
  - MTC0 to any other register is unaffected.

## Timing
- Reset: Status = 0, Cause = 0, EPC = 0, state RUN, synchronizer flops 0. Outputs: `intr` = 0, `exc_redirect` = 0, `exc_target` = `EXC_VECTOR`, `rd_cp0_data` = 0 for address 0.
- `exc_redirect`/`exc_target` are combinational, in the same cycle as the event, so they align with the control unit's IF/ID flush. Register updates land at the next rising edge.
- MTC0 takes effect at the next edge. MFC0 in the same cycle returns the old value; there is no bypass.
- `hw_int` → IP latency: 2 cycles of synchronization, so `intr` rises 2 edges after `hw_int` if unmasked.
- `pause` high blocks all events; retried once `pause` falls if still present.
- Reset asserted mid-handler returns immediately to RUN with all registers at their reset values.

## Configuration
- `CP0_COUNT_COMPARE_EN` defined:
  - Count (reg 9) increments every cycle and wraps at 2^32. Reset 0.
  - Compare (reg 11) resets to 32'hFFFF_FFFF.
  - When Count == Compare, a timer-pending flop sets; it is ORed into IP[7] and cleared by an MTC0 to Compare.
- Undefined: regs 9/11 read 0, and IP[7] reflects `hw_int[5]` only.

## Structure
- Shared package `cp0_pkg` holds:
  - Register numbers (9, 11, 12, 13, 14).
  - Status/Cause bit positions.
  - ExcCode values.
  - SYSCALL/ERET opcode/function constants, shared with the control unit's instruction constants.
- One sub-module, `cp0_int_sync`: a 6-bit two-flop synchronizer clocked by `clk`, reset by `rst`.

## Test plan
- Reset, then MFC0 12/13/14 → all 0; `intr` = 0; `exc_redirect` = 0.
- MTC0 12 ← 0x0000_0403 (IE, SE, IM2), `hw_int[0]` = 1 → `intr` = 1 after 2 edges. Then `cu_intr` with `id_pc` = 0x100 → same-cycle redirect to 0x180. Next cycle: EPC = 0x100, ExcCode = 0, EXL = 1, IE = 0, `intr` = 0.
- SYSCALL in ID with SE = 1, `id_pc` = 0x200 → redirect to 0x180, EPC = 0x204, ExcCode = 8. With SE = 0 → no redirect, registers unchanged.
- ERET with EPC = 0x204 → redirect to 0x204; EXL = 0, IE = 1.
- `pause` = 1 with `cu_intr` = 1 and SYSCALL in ID → no redirect, no register change. Then release `pause` → event taken.
- With `CP0_COUNT_COMPARE_EN`: MTC0 11 ← 20, IM7 set → IP[7] = 1 when Count reaches 20. MTC0 11 → IP[7] clears.
